// File: rtl/com_port_pkg.sv
// Shared types and constants for the cartridge PORT strobe generator.
package com_port_pkg;

    localparam int unsigned WAIT_W    = 2;
    localparam logic [3:0]  PORT_BASE = 4'h2;

    typedef enum logic [2:0] {
        IDLE,
        ADRS,
        WAIT,
        STROBE,
        RELEASE
    } port_state_e;

endpackage

// File: rtl/port_strobe_gen.sv
// Decodes 68k cycles to the cartridge PORT region and generates registered
// byte-lane OE/WE strobes, nPORTADRS and a local DTACK with programmable waits.
module port_strobe_gen #(
    parameter logic [3:0]  PORT_BASE = com_port_pkg::PORT_BASE,
    parameter int unsigned WAIT_W    = com_port_pkg::WAIT_W
) (
    input  logic              CLK_24M,
    input  logic              nRESET,
    input  logic              CLK_EN_68K,
    input  logic [23:1]       M68K_ADDR,
    input  logic              M68K_RW,
    input  logic              nAS,
    input  logic              nLDS,
    input  logic              nUDS,
    input  logic [WAIT_W-1:0] PORT_WAIT,
    output logic              nPORTADRS,
    output logic              nPORTOEL,
    output logic              nPORTOEU,
    output logic              nPORTWEL,
    output logic              nPORTWEU,
    output logic              nDTACK_PORT,
    output logic              PORT_ACTIVE
);

    import com_port_pkg::*;

    port_state_e       state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              rw_q;
    logic              lds_l_q;
    logic              uds_l_q;
    logic              adrs_n_q;
    logic              oel_n_q;
    logic              oeu_n_q;
    logic              wel_n_q;
    logic              weu_n_q;
    logic              dtack_n_q;
    logic              active_q;

    logic              hit;
    logic              ds_any;
    logic              unused_addr;

    assign hit         = ~nAS & (M68K_ADDR[23:20] == PORT_BASE);
    assign ds_any      = ~nLDS | ~nUDS;
    assign unused_addr = ^M68K_ADDR[19:1];

    // Sequencer: the abort and release paths watch nAS every CLK_24M cycle,
    // while forward progress through ADRS/WAIT is paced by the 68k enable.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            rw_q       <= 1'b1;
            lds_l_q    <= 1'b0;
            uds_l_q    <= 1'b0;
            adrs_n_q   <= 1'b1;
            oel_n_q    <= 1'b1;
            oeu_n_q    <= 1'b1;
            wel_n_q    <= 1'b1;
            weu_n_q    <= 1'b1;
            dtack_n_q  <= 1'b1;
            active_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (CLK_EN_68K && hit) begin
                        state_q    <= ADRS;
                        adrs_n_q   <= 1'b0;
                        wait_cnt_q <= PORT_WAIT;
                        rw_q       <= M68K_RW;
                        active_q   <= 1'b1;
                    end
                end
                ADRS: begin
                    if (nAS) begin
                        state_q  <= IDLE;
                        adrs_n_q <= 1'b1;
                        active_q <= 1'b0;
                    end else if (CLK_EN_68K) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (nAS) begin
                        state_q  <= IDLE;
                        adrs_n_q <= 1'b1;
                        active_q <= 1'b0;
                    end else if (CLK_EN_68K) begin
                        if (wait_cnt_q != '0) begin
                            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                        end else if (ds_any) begin
                            state_q   <= STROBE;
                            lds_l_q   <= ~nLDS;
                            uds_l_q   <= ~nUDS;
                            oel_n_q   <= ~(rw_q & ~nLDS);
                            oeu_n_q   <= ~(rw_q & ~nUDS);
                            wel_n_q   <= ~(~rw_q & ~nLDS);
                            weu_n_q   <= ~(~rw_q & ~nUDS);
                            dtack_n_q <= 1'b0;
                        end
                    end
                end
                STROBE: begin
                    if (nAS) begin
                        state_q   <= RELEASE;
                        adrs_n_q  <= 1'b1;
                        oel_n_q   <= 1'b1;
                        oeu_n_q   <= 1'b1;
                        wel_n_q   <= 1'b1;
                        weu_n_q   <= 1'b1;
                        dtack_n_q <= 1'b1;
                    end else begin
                        // Lanes stay frozen to the set captured on entry.
                        oel_n_q <= ~(rw_q & lds_l_q);
                        oeu_n_q <= ~(rw_q & uds_l_q);
                        wel_n_q <= ~(~rw_q & lds_l_q);
                        weu_n_q <= ~(~rw_q & uds_l_q);
                    end
                end
                RELEASE: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign nPORTADRS   = adrs_n_q;
    assign nPORTOEL    = oel_n_q;
    assign nPORTOEU    = oeu_n_q;
    assign nPORTWEL    = wel_n_q;
    assign nPORTWEU    = weu_n_q;
    assign nDTACK_PORT = dtack_n_q;
    assign PORT_ACTIVE = active_q;

endmodule

// File: tb/tb_port_strobe_gen.sv
// Self-checking bench for port_strobe_gen: directed scenarios plus random
// bus cycles compared every cycle against a transaction-level model.
module tb_port_strobe_gen;

    logic        CLK_24M;
    logic        nRESET;
    logic        CLK_EN_68K;
    logic [23:1] M68K_ADDR;
    logic        M68K_RW;
    logic        nAS;
    logic        nLDS;
    logic        nUDS;
    logic [1:0]  PORT_WAIT;
    logic        nPORTADRS;
    logic        nPORTOEL;
    logic        nPORTOEU;
    logic        nPORTWEL;
    logic        nPORTWEU;
    logic        nDTACK_PORT;
    logic        PORT_ACTIVE;

    port_strobe_gen dut (
        .CLK_24M    (CLK_24M),
        .nRESET     (nRESET),
        .CLK_EN_68K (CLK_EN_68K),
        .M68K_ADDR  (M68K_ADDR),
        .M68K_RW    (M68K_RW),
        .nAS        (nAS),
        .nLDS       (nLDS),
        .nUDS       (nUDS),
        .PORT_WAIT  (PORT_WAIT),
        .nPORTADRS  (nPORTADRS),
        .nPORTOEL   (nPORTOEL),
        .nPORTOEU   (nPORTOEU),
        .nPORTWEL   (nPORTWEL),
        .nPORTWEU   (nPORTWEU),
        .nDTACK_PORT(nDTACK_PORT),
        .PORT_ACTIVE(PORT_ACTIVE)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int en_seen  = 0;
    int wel_rise = 0;
    bit prev_wel = 1'b1;
    bit strobe_seen;
    bit any_seen;
    bit chk_en   = 1'b0;

    // Model: a cycle is "busy" from acceptance until the cool-down cycle ends;
    // en_left counts 68k enables still owed before data strobes are honoured.
    bit m_busy   = 1'b0;
    bit m_strobe = 1'b0;
    bit m_tail   = 1'b0;
    bit m_rd     = 1'b0;
    bit m_l      = 1'b0;
    bit m_u      = 1'b0;
    int m_en_left = 0;

    initial begin
        CLK_24M = 1'b0;
        forever #5 CLK_24M = ~CLK_24M;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    always @(posedge CLK_24M) begin
        if (CLK_EN_68K) en_seen++;
        if (!nRESET) begin
            m_busy = 0; m_strobe = 0; m_tail = 0; m_en_left = 0;
        end else if (m_tail) begin
            m_tail = 0; m_busy = 0;
        end else if (m_strobe) begin
            if (nAS) begin m_strobe = 0; m_tail = 1; end
        end else if (m_busy) begin
            if (nAS) begin
                m_busy = 0;
            end else if (CLK_EN_68K) begin
                if (m_en_left > 0) m_en_left--;
                else if (!nLDS || !nUDS) begin
                    m_strobe = 1; m_l = !nLDS; m_u = !nUDS;
                end
            end
        end else if (CLK_EN_68K && !nAS && M68K_ADDR[23:20] == 4'h2) begin
            m_busy = 1; m_en_left = int'(PORT_WAIT) + 1; m_rd = M68K_RW;
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %b required %b", name, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, got, exp);
        end
    endtask

    always @(negedge CLK_24M) begin
        if (chk_en) begin
            chk("model_nPORTADRS", nPORTADRS, !(m_busy && !m_tail));
            chk("model_nPORTOEL", nPORTOEL, !(m_strobe && m_rd && m_l));
            chk("model_nPORTOEU", nPORTOEU, !(m_strobe && m_rd && m_u));
            chk("model_nPORTWEL", nPORTWEL, !(m_strobe && !m_rd && m_l));
            chk("model_nPORTWEU", nPORTWEU, !(m_strobe && !m_rd && m_u));
            chk("model_nDTACK_PORT", nDTACK_PORT, !m_strobe);
            chk("model_PORT_ACTIVE", PORT_ACTIVE, m_busy);
        end
    end

    function automatic logic [23:1] ba(input logic [23:0] x);
        ba = x[23:1];
    endfunction

    task automatic step();
        @(negedge CLK_24M);
        cyc++;
        CLK_EN_68K = (cyc % 3 == 0);
        if (!(nPORTOEL & nPORTOEU & nPORTWEL & nPORTWEU)) strobe_seen = 1'b1;
        if (!nPORTADRS || PORT_ACTIVE || !nDTACK_PORT) any_seen = 1'b1;
        if (!prev_wel && nPORTWEL) wel_rise++;
        prev_wel = nPORTWEL;
    endtask

    task automatic step_to_en();
        step();
        while (!CLK_EN_68K) step();
    endtask

    task automatic wait_strobe(input string name, input int limit);
        int k;
        k = 0;
        while ((nPORTOEL & nPORTOEU & nPORTWEL & nPORTWEU) && k < limit) begin
            step();
            k++;
        end
        if (nPORTOEL & nPORTOEU & nPORTWEL & nPORTWEU) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no strobe after %0d cycles required a strobe", name, limit);
        end
    endtask

    task automatic bus_idle();
        nAS = 1'b1; nLDS = 1'b1; nUDS = 1'b1; M68K_RW = 1'b1;
    endtask

    initial begin
        int hit_en;
        int k;
        int limit;
        int r;
        bit abort;
        int ds_delay;
        int abort_at;
        logic [3:0] hi;
        logic [1:0] lanes;

        nRESET = 1'b0; CLK_EN_68K = 1'b0; PORT_WAIT = 2'd0;
        M68K_ADDR = '0;
        bus_idle();
        repeat (4) step();
        chk_en = 1'b1;
        nRESET = 1'b1;
        step();
        chk("reset_nPORTADRS", nPORTADRS, 1'b1);
        chk("reset_nPORTWEL", nPORTWEL, 1'b1);
        chk("reset_nDTACK", nDTACK_PORT, 1'b1);
        chk("reset_active", PORT_ACTIVE, 1'b0);

        // Word write to $200000, no waits.
        step_to_en();
        hit_en = en_seen + 1;
        M68K_ADDR = ba(24'h200000); M68K_RW = 1'b0; PORT_WAIT = 2'd0;
        nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b0;
        step();
        chk("t1_adrs_low", nPORTADRS, 1'b0);
        chk("t1_active", PORT_ACTIVE, 1'b1);
        chk("t1_we_not_yet", nPORTWEL, 1'b1);
        wait_strobe("t1_wait", 30);
        chk_int("t1_enables_to_we", en_seen - hit_en, 2);
        chk("t1_wel", nPORTWEL, 1'b0);
        chk("t1_weu", nPORTWEU, 1'b0);
        chk("t1_oel", nPORTOEL, 1'b1);
        chk("t1_dtack", nDTACK_PORT, 1'b0);
        repeat (2) step();
        bus_idle();
        step();
        chk("t1_wel_release", nPORTWEL, 1'b1);
        chk("t1_weu_release", nPORTWEU, 1'b1);
        chk("t1_dtack_release", nDTACK_PORT, 1'b1);
        chk("t1_active_in_release", PORT_ACTIVE, 1'b1);
        step();
        chk("t1_active_after", PORT_ACTIVE, 1'b0);

        // Byte read from $200001, three wait states.
        step_to_en();
        hit_en = en_seen + 1;
        M68K_ADDR = ba(24'h200001); M68K_RW = 1'b1; PORT_WAIT = 2'd3;
        nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b1;
        step();
        wait_strobe("t2_wait", 40);
        chk_int("t2_enables_to_oe", en_seen - hit_en, 5);
        chk("t2_oel", nPORTOEL, 1'b0);
        chk("t2_oeu", nPORTOEU, 1'b1);
        chk("t2_wel", nPORTWEL, 1'b1);
        chk("t2_weu", nPORTWEU, 1'b1);
        step();
        bus_idle();
        repeat (2) step();

        // Write with a late lower data strobe; lane set frozen inside STROBE.
        wel_rise = 0;
        step_to_en();
        hit_en = en_seen + 1;
        M68K_ADDR = ba(24'h200010); M68K_RW = 1'b0; PORT_WAIT = 2'd0;
        nAS = 1'b0; nLDS = 1'b1; nUDS = 1'b1;
        step();
        k = 0;
        while (en_seen < hit_en + 2 && k < 20) begin step(); k++; end
        chk("t3_held_active", PORT_ACTIVE, 1'b1);
        chk("t3_held_no_we", nPORTWEL, 1'b1);
        nLDS = 1'b0;
        wait_strobe("t3_wait", 20);
        chk_int("t3_enables_to_we", en_seen - hit_en, 3);
        chk("t3_wel", nPORTWEL, 1'b0);
        nUDS = 1'b0;
        repeat (4) step();
        chk("t3_weu_frozen", nPORTWEU, 1'b1);
        bus_idle();
        repeat (3) step();
        chk_int("t3_wel_rising_edges", wel_rise, 1);

        // Abort while waiting.
        strobe_seen = 1'b0;
        step_to_en();
        hit_en = en_seen + 1;
        M68K_ADDR = ba(24'h200000); M68K_RW = 1'b0; PORT_WAIT = 2'd3;
        nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b0;
        step();
        k = 0;
        while (en_seen < hit_en + 2 && k < 20) begin step(); k++; end
        bus_idle();
        step();
        chk("t4_adrs_back", nPORTADRS, 1'b1);
        chk("t4_active_off", PORT_ACTIVE, 1'b0);
        repeat (6) step();
        chk("t4_no_strobe", strobe_seen, 1'b0);

        // Reset in the middle of a write strobe, then a clean write to $2FFFFE.
        step_to_en();
        M68K_ADDR = ba(24'h200000); M68K_RW = 1'b0; PORT_WAIT = 2'd1;
        nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b0;
        step();
        wait_strobe("t5_wait", 30);
        nRESET = 1'b0;
        step();
        chk("t5_rst_wel", nPORTWEL, 1'b1);
        chk("t5_rst_weu", nPORTWEU, 1'b1);
        chk("t5_rst_adrs", nPORTADRS, 1'b1);
        chk("t5_rst_active", PORT_ACTIVE, 1'b0);
        nRESET = 1'b1;
        bus_idle();
        repeat (2) step();
        step_to_en();
        M68K_ADDR = ba(24'h2FFFFE); M68K_RW = 1'b0; PORT_WAIT = 2'd0;
        nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b0;
        step();
        wait_strobe("t5_after_wait", 30);
        chk("t5_after_wel", nPORTWEL, 1'b0);
        chk("t5_after_weu", nPORTWEU, 1'b0);
        bus_idle();
        repeat (2) step();
        chk("t5_after_idle", PORT_ACTIVE, 1'b0);

        // Accesses outside the PORT region.
        any_seen = 1'b0;
        step_to_en();
        M68K_ADDR = ba(24'h300000); M68K_RW = 1'b1;
        nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b0;
        repeat (12) step();
        bus_idle();
        repeat (2) step();
        M68K_ADDR = ba(24'h1FFFFE); M68K_RW = 1'b0;
        nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b0;
        repeat (12) step();
        bus_idle();
        repeat (2) step();
        chk("t6_nothing_toggled", any_seen, 1'b0);

        // Random bus cycles, including aborts, late strobes and wait changes.
        for (int t = 0; t < 200; t++) begin
            repeat ($urandom_range(0, 3)) step();
            r = $urandom_range(0, 9);
            if (r < 7) hi = 4'h2;
            else begin
                case ($urandom_range(0, 3))
                    0:       hi = 4'h3;
                    1:       hi = 4'h1;
                    2:       hi = 4'hF;
                    default: hi = 4'h0;
                endcase
            end
            M68K_ADDR = {hi, 19'($urandom)};
            M68K_RW   = 1'($urandom);
            PORT_WAIT = 2'($urandom);
            lanes     = 2'($urandom_range(1, 3));
            ds_delay  = $urandom_range(0, 6);
            abort     = ($urandom_range(0, 5) == 0);
            abort_at  = $urandom_range(0, 8);
            limit     = (hi == 4'h2) ? 45 : 12;
            nAS = 1'b0;
            for (int j = 0; j < limit; j++) begin
                if (j == ds_delay) {nUDS, nLDS} = ~lanes;
                if (abort && j == abort_at) break;
                if ($urandom_range(0, 7) == 0) PORT_WAIT = 2'($urandom);
                step();
                if (m_strobe) break;
            end
            if (m_strobe) begin
                for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                    if ($urandom_range(0, 2) == 0) {nUDS, nLDS} = 2'($urandom);
                    step();
                end
            end
            bus_idle();
            repeat ($urandom_range(1, 2)) step();
        end
        bus_idle();
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/port_strobe_gen.md
Name: port_strobe_gen

Overview:
- Decodes 68000 bus cycles aimed at the cartridge PORT region ($200000-$2FFFFF) and generates the active-low byte-lane strobes nPORTOEL/nPORTOEU/nPORTWEL/nPORTWEU, plus nPORTADRS.
- Sits directly upstream of the COM idle-reply responder and the other PORT-mapped cart peripherals.
- Inserts 0-3 programmable wait states and returns a local nDTACK_PORT.
- Guarantees exactly one clean rising edge per write strobe, so downstream edge detectors toggle once per write.

Parameters:
- PORT_BASE, 4'h2, value of M68K_ADDR[23:20] selecting the PORT region.
- WAIT_W, 2, width of the wait-state count.

Ports:
- CLK_24M  in  1  system clock.
- nRESET  in  1  reset, synchronous, active-low.
- CLK_EN_68K  in  1  one-CLK_24M-cycle enable marking each 68k clock rising edge.
- M68K_ADDR  in  23  68k address bits [23:1].
- M68K_RW  in  1  1=read, 0=write.
- nAS  in  1  68k address strobe.
- nLDS  in  1  lower data strobe.
- nUDS  in  1  upper data strobe.
- PORT_WAIT  in  WAIT_W  wait states to insert (0-3).
- nPORTADRS  out  1  address-valid strobe to cart.
- nPORTOEL  out  1  read strobe, D[7:0].
- nPORTOEU  out  1  read strobe, D[15:8].
- nPORTWEL  out  1  write strobe, D[7:0].
- nPORTWEU  out  1  write strobe, D[15:8].
- nDTACK_PORT  out  1  local acknowledge to the 68k DTACK merge.
- PORT_ACTIVE  out  1  high while a PORT cycle is in progress (state != IDLE).

Behaviour:
- All outputs are registered.
- Reset: state IDLE; all n* outputs 1; PORT_ACTIVE 0. Reset asserted mid-cycle releases every strobe on the next CLK_24M edge.
- HIT = ~nAS & (M68K_ADDR[23:20]==PORT_BASE).
- FSM states: IDLE, ADRS, WAIT, STROBE, RELEASE.
- IDLE -> ADRS: on a CLK_EN_68K cycle with HIT.
  - nPORTADRS goes low.
  - PORT_WAIT latched into the wait counter.
  - M68K_RW latched.
- ADRS -> WAIT: on the next CLK_EN_68K.
- WAIT:
  - Counter decrements once per CLK_EN_68K while nonzero.
  - When counter==0 and (~nLDS | ~nUDS) on a CLK_EN_68K, go to STROBE and latch the lane strobes LDS_L and UDS_L.
  - If both data strobes are high, hold in WAIT with counter at 0.
- STROBE:
  - Read: nPORTOEL = ~LDS_L, nPORTOEU = ~UDS_L.
  - Write: nPORTWEL = ~LDS_L, nPORTWEU = ~UDS_L.
  - nDTACK_PORT = 0.
  - nPORTADRS stays 0.
- STROBE -> RELEASE: sampled every CLK_24M cycle (not enable-gated) when nAS==1.
  - All n* outputs go to 1 in the same registered update.
  - The strobe release therefore lags nAS rising by exactly 1 CLK_24M cycle.
- RELEASE -> IDLE: unconditionally after 1 CLK_24M cycle.
  - Guarantees at least 1 idle cycle between back-to-back PORT cycles.
  - A HIT seen in RELEASE is not accepted.
- Abort: nAS high while in ADRS or WAIT -> IDLE on that CLK_24M cycle. No OE/WE strobe occurs and nPORTADRS returns to 1.
- Read and write strobes are never asserted together.
- The lane set is frozen for the whole STROBE state; DS changes inside STROBE are ignored.
- Latency, PORT_WAIT=0: HIT at enable n -> ADRS after enable n; STROBE after enable n+2 (WAIT spans enable n+1).
- Latency, PORT_WAIT=k: STROBE after enable n+2+k.
- PORT_WAIT changes during a cycle have no effect until the next ADRS entry.
- Non-PORT addresses: no output ever leaves its inactive level.

Decomposition:
- Package com_port_pkg holds:
  - the state enum (IDLE, ADRS, WAIT, STROBE, RELEASE);
  - the PORT_BASE default;
  - the WAIT_W constant.
- No sub-module: the wait counter and lane latch are small enough to live inline in port_strobe_gen.

Test Plan:
- Reset, then word write to $200000 with PORT_WAIT=0 -> nPORTADRS low 1 enable after HIT; nPORTWEL and nPORTWEU low 2 enables after that; both rise exactly 1 CLK_24M after nAS rises; nDTACK_PORT low only during STROBE.
- Byte read from $200001 (nLDS=0, nUDS=1), PORT_WAIT=3 -> only nPORTOEL asserts, 5 enables after HIT; nPORTOEU, nPORTWEL and nPORTWEU stay 1 throughout.
- Write where nLDS falls 2 enables after nAS -> FSM holds in WAIT; nPORTWEL asserts on the first enable with nLDS low; a single rising edge of nPORTWEL per cycle.
- nAS deasserted while in WAIT (PORT_WAIT=3) -> return to IDLE; no OE/WE pulse; nPORTADRS back to 1 the next CLK_24M.
- nRESET asserted mid-STROBE during a write -> all strobes 1 and PORT_ACTIVE 0 on the next edge; after release, a new write to $2FFFFE completes normally.
- Access to $300000 and $1FFFFE -> no output toggles; PORT_ACTIVE stays 0.
